cnt_readout: RTL and testbench

CNT_READOUT -- requirements
Module: cnt_readout

---
 rtl/cnt_readout_if.sv | 26 ++
 rtl/cnt_readout.sv | 95 +++++++++
 tb/tb_cnt_readout.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cnt_readout_if.sv
// Signal bundle between cnt_readout and its environment: measurement control,
// the count-enable window, the two error counts and the serial readout frame.
interface cnt_readout_if;
  logic        go;
  logic        abort;
  logic [15:0] win_len;
  logic        start;
  logic [31:0] error_origin_cnt;
  logic [31:0] error_ptr_cnt;
  logic        sdo;
  logic        sdo_valid;
  logic        sdo_first;
  logic        busy;
  logic        done;
  logic        sat;

  modport master (
    output go, abort, win_len, error_origin_cnt, error_ptr_cnt,
    input  start, sdo, sdo_valid, sdo_first, busy, done, sat
  );

  modport slave (
    input  go, abort, win_len, error_origin_cnt, error_ptr_cnt,
    output start, sdo, sdo_valid, sdo_first, busy, done, sat
  );
endinterface

// File: rtl/cnt_readout.sv
// Opens a count window, waits for the counters to settle, captures both error
// counts and shifts them out MSB first. CNT_READOUT_PARITY_EN appends an even-parity bit.
module cnt_readout (
  input logic          clk,
  input logic          rst_n,
  cnt_readout_if.slave bus
);

`ifdef CNT_READOUT_PARITY_EN
  localparam int FRAME_BITS = 65;
`else
  localparam int FRAME_BITS = 64;
`endif
  localparam logic [6:0] LAST_BIT = 7'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, RUN, SETTLE, CAPTURE, SHIFT, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [15:0]           win_cnt;
  logic [1:0]            settle_cnt;
  logic [6:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  sat_q;
  logic [63:0]           frame_data;

  assign frame_data = {bus.error_origin_cnt, bus.error_ptr_cnt};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // abort wins over everything, including a go seen in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.go) state_next = (bus.win_len != 16'd0) ? RUN : SETTLE;
      RUN:     if (win_cnt == 16'd1) state_next = SETTLE;
      SETTLE:  if (settle_cnt == 2'd3) state_next = CAPTURE;
      CAPTURE: state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.abort) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt    <= 16'd0;
      settle_cnt <= 2'd0;
      bit_cnt    <= 7'd0;
      shreg      <= '0;
      sat_q      <= 1'b0;
    end else if (bus.abort) begin
      win_cnt    <= 16'd0;
      settle_cnt <= 2'd0;
      bit_cnt    <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          settle_cnt <= 2'd0;
          bit_cnt    <= 7'd0;
          if (bus.go) win_cnt <= bus.win_len;
        end
        RUN:    win_cnt <= win_cnt - 16'd1;
        SETTLE: settle_cnt <= settle_cnt + 2'd1;
        CAPTURE: begin
`ifdef CNT_READOUT_PARITY_EN
          shreg <= {frame_data, ^frame_data};
`else
          shreg <= frame_data;
`endif
          sat_q   <= (&bus.error_origin_cnt) | (&bus.error_ptr_cnt);
          bit_cnt <= 7'd0;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 7'd1;
        end
        default: bit_cnt <= 7'd0;
      endcase
    end
  end

  assign bus.start     = (state == RUN);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.sdo_valid = (state == SHIFT);
  assign bus.sdo_first = (state == SHIFT) && (bit_cnt == 7'd0);
  assign bus.sdo       = (state == SHIFT) && shreg[FRAME_BITS-1];
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_cnt_readout.sv
// Directed self-checking bench for cnt_readout: window length, settle/capture
// latency, frame contents, saturation flag, go filtering, abort and reset.
module tb_cnt_readout;

`ifdef CNT_READOUT_PARITY_EN
  localparam int FB = 65;
`else
  localparam int FB = 64;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cnt_readout_if bus ();

  cnt_readout dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic go, input logic abort, input logic [15:0] win,
                               input logic [31:0] origin, input logic [31:0] ptr);
    bus.go               = go;
    bus.abort            = abort;
    bus.win_len          = win;
    bus.error_origin_cnt = origin;
    bus.error_ptr_cnt    = ptr;
  endtask

  function automatic logic [64:0] expectedFrame(input logic [63:0] data);
`ifdef CNT_READOUT_PARITY_EN
    return {data, ^data};
`else
    return {1'b0, data};
`endif
  endfunction

  function automatic logic [64:0] outVec();
    return 65'({bus.start, bus.sdo, bus.sdo_valid, bus.sdo_first, bus.busy, bus.done, bus.sat});
  endfunction

  // One full measurement: go, window, settle, capture, frame, done, back to idle
  task automatic runFrame(input string tag, input logic [15:0] win, input logic [31:0] origin,
                          input logic [31:0] ptr, input logic exp_sat, output logic [64:0] frame);
    int start_cnt   = 0;
    int early_valid = 0;
    int early_sdo   = 0;
    int valid_cnt   = 0;
    int first_cnt   = 0;
    frame = '0;
    applyStimulus(1'b1, 1'b0, win, origin, ptr);
    tick();
    bus.go = 1'b0;
    for (int c = 1; c < int'(win) + 6; c++) begin
      start_cnt   += int'(bus.start);
      early_valid += int'(bus.sdo_valid);
      early_sdo   += int'(bus.sdo);
      tick();
    end
    checkOutput({tag, " start_cycles"}, 65'(start_cnt), 65'(win));
    checkOutput({tag, " early_valid_or_sdo"}, 65'(early_valid + early_sdo), 65'(0));
    checkOutput({tag, " first_bit_latency"}, 65'({bus.sdo_valid, bus.sdo_first}), 65'(3));
    for (int b = 0; b < FB; b++) begin
      frame = {frame[63:0], bus.sdo};
      valid_cnt += int'(bus.sdo_valid);
      first_cnt += int'(bus.sdo_first);
      tick();
    end
    checkOutput({tag, " frame"}, frame, expectedFrame({origin, ptr}));
    checkOutput({tag, " valid_first_counts"}, 65'({valid_cnt, first_cnt}), 65'({FB, 1}));
    checkOutput({tag, " done_pulse"}, 65'({bus.done, bus.sdo_valid, bus.busy}), 65'(3'b101));
    tick();
    checkOutput({tag, " idle_after"}, 65'({bus.done, bus.busy, bus.start}), 65'(0));
    checkOutput({tag, " sat"}, 65'(bus.sat), 65'(exp_sat));
  endtask

  initial begin
    logic [64:0] frame;
    int busy_cnt;
    int done_cnt;
    int first_cnt;
    int acc;

    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_outputs", outVec(), 65'(0));

    // First go is taken on the very first edge with reset released
    rst_n = 1'b1;
    runFrame("win10", 16'd10, 32'h0000_0003, 32'h8000_0001, 1'b0, frame);
    runFrame("win0", 16'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, frame);
    runFrame("sat_origin", 16'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, frame);

    // Abort in RUN must leave the previous sat untouched
    applyStimulus(1'b1, 1'b0, 16'd5, 32'd0, 32'd0);
    tick();
    bus.go = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("abort_run_outputs", 65'({bus.busy, bus.start, bus.sdo_valid, bus.done}), 65'(0));
    checkOutput("abort_run_sat_kept", 65'(bus.sat), 65'(1));

    // Abort on the 20th frame bit: no done pulse afterwards
    applyStimulus(1'b1, 1'b0, 16'd0, 32'h0000_00AA, 32'h0000_0055);
    tick();
    bus.go = 1'b0;
    for (int c = 1; c < 25; c++) tick();
    checkOutput("abort_shift_valid_before", 65'(bus.sdo_valid), 65'(1));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("abort_shift_outputs", 65'({bus.sdo_valid, bus.sdo, bus.busy, bus.done}), 65'(0));
    acc = 0;
    for (int c = 0; c < 80; c++) begin
      acc += int'(bus.done) + int'(bus.busy);
      tick();
    end
    checkOutput("abort_shift_no_done", 65'(acc), 65'(0));
    checkOutput("abort_shift_sat", 65'(bus.sat), 65'(0));

    // go repeats at +5, +40 and on the done cycle are all ignored
    applyStimulus(1'b0, 1'b0, 16'd3, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    busy_cnt  = 0;
    done_cnt  = 0;
    first_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      busy_cnt  += int'(bus.busy);
      done_cnt  += int'(bus.done);
      first_cnt += int'(bus.sdo_first);
      bus.go = (c == 0) || (c == 5) || (c == 40) || (c == 3 + 6 + FB);
      tick();
    end
    bus.go = 1'b0;
    checkOutput("go_ignored_busy_cycles", 65'(busy_cnt), 65'(3 + 6 + FB));
    checkOutput("go_ignored_done_count", 65'(done_cnt), 65'(1));
    checkOutput("go_ignored_frame_count", 65'(first_cnt), 65'(1));

    // Reset in the middle of RUN, then a fresh go on the first released edge
    applyStimulus(1'b1, 1'b0, 16'd20, 32'd7, 32'd9);
    tick();
    bus.go = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checkOutput("run_before_reset", 65'(bus.start), 65'(1));
    rst_n = 1'b0;
    tick();
    checkOutput("reset_mid_run", outVec(), 65'(0));
    rst_n = 1'b1;
    runFrame("after_reset", 16'd2, 32'hA5A5_A5A5, 32'h0000_0001, 1'b0, frame);

    runFrame("ptr_sat", 16'd1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, frame);
    runFrame("win_max", 16'hFFFF, 32'h8000_0000, 32'h0000_0001, 1'b0, frame);

`ifdef CNT_READOUT_PARITY_EN
    runFrame("parity", 16'd4, 32'h0000_0001, 32'h0000_0000, 1'b0, frame);
    checkOutput("parity_bit", 65'(frame[0]), 65'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
